// File: rtl/sqrt_arb_pkg.sv
// Shared definitions for the sqrt_arbiter block.
//   state_t        : controller FSM encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
//   OP_W / RES_W   : operand and result widths of the shared sqrt core
//   WDOG_LIMIT_DEF : default WAIT-state watchdog limit (used only when
//                    SQRT_ARB_WATCHDOG_EN is defined)
package sqrt_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int OP_W           = 32;
  localparam int RES_W          = 16;
  localparam int WDOG_LIMIT_DEF = 40;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant search.
//   req     [N]         : request vector
//   ptr     [clog2(N)]  : index that has highest priority this cycle
//   gnt     [N]         : one-hot grant (all zero when no request)
//   gnt_idx [clog2(N)]  : binary index of the granted requester
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IDX_W = $clog2(N);

  // Walk the requesters starting at ptr, wrapping modulo N; the first
  // valid one found wins.
  always_comb begin : p_search
    logic [IDX_W-1:0] cand;
    logic             found;
    cand    = '0;
    found   = 1'b0;
    gnt     = '0;
    gnt_idx = '0;
    for (int k = 0; k < N; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found        = 1'b1;
        gnt[cand]    = 1'b1;
        gnt_idx      = cand;
      end
    end
  end

endmodule

// File: rtl/sqrt_arbiter.sv
// Shares one sqrt core among N requesters with round-robin arbitration.
// One operand is accepted in IDLE, issued to the core, the core's one-cycle
// ready pulse is captured, and the result is held on the response port
// until consumed.
//
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   req_valid[N], req_data    : per-requester operands (32 bits each)
//   req_ready[N]              : one-hot combinational accept strobe
//   rsp_valid/rsp_ready       : response handshake
//   rsp_id, rsp_result,
//   rsp_cflag, rsp_oflag,
//   rsp_err                   : held response fields
//   core_start, core_nr       : drive the shared core
//   core_ready, core_result,
//   core_cflag, core_oflag    : core outputs (valid only while ready=1)
//   core_rst                  : core reset pulse on watchdog abort
//
// Build option: define SQRT_ARB_WATCHDOG_EN to abort a WAIT that lasts
// WDOG_LIMIT cycles; otherwise core_rst and rsp_err are tied to 0.
module sqrt_arbiter
  import sqrt_arb_pkg::*;
#(
  parameter int N          = 4,
  parameter int WDOG_LIMIT = WDOG_LIMIT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req_valid,
  input  logic [32*N-1:0]        req_data,
  output logic [N-1:0]           req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [$clog2(N)-1:0]   rsp_id,
  output logic [RES_W-1:0]       rsp_result,
  output logic                   rsp_cflag,
  output logic                   rsp_oflag,
  output logic                   rsp_err,
  output logic                   core_start,
  output logic [OP_W-1:0]        core_nr,
  input  logic                   core_ready,
  input  logic [RES_W-1:0]       core_result,
  input  logic                   core_cflag,
  input  logic                   core_oflag,
  output logic                   core_rst
);

  localparam int IDX_W = $clog2(N);

  if (N < 2 || N > 8) begin : g_bad_n
    $error("sqrt_arbiter: N must be in 2..8");
  end
  // The watchdog counter is 6 bits wide.
  if (WDOG_LIMIT < 1 || WDOG_LIMIT > 63) begin : g_bad_wdog
    $error("sqrt_arbiter: WDOG_LIMIT must be in 1..63");
  end

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  ptr, ptr_nxt;
  logic [OP_W-1:0]   op_q;
  logic [IDX_W-1:0]  id_q;
  logic [RES_W-1:0]  res_q;
  logic              cflag_q, oflag_q;
  logic              accept, capture, start_c;

  logic [N-1:0]      gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic [OP_W-1:0]   req_arr [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign req_arr[i] = req_data[32*i +: 32];
  end

  rr_arbiter #(.N(N)) u_rr (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign ptr_nxt = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;

`ifdef SQRT_ARB_WATCHDOG_EN
  localparam logic [5:0] WDOG_CNT_LIM = 6'(WDOG_LIMIT);
  logic [5:0] wdog_cnt;
  logic       wd_abort;
  logic       err_q;
`endif

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    start_c   = 1'b0;
`ifdef SQRT_ARB_WATCHDOG_EN
    wd_abort  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (|req_valid) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        start_c   = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        // The core's outputs are only valid in its ready cycle, so the
        // capture must happen right here; a simultaneous watchdog hit loses.
        if (core_ready) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
`ifdef SQRT_ARB_WATCHDOG_EN
        else if (wdog_cnt == WDOG_CNT_LIM) begin
          wd_abort  = 1'b1;
          state_nxt = RESP;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      op_q    <= '0;
      id_q    <= '0;
      res_q   <= '0;
      cflag_q <= 1'b0;
      oflag_q <= 1'b0;
`ifdef SQRT_ARB_WATCHDOG_EN
      err_q    <= 1'b0;
      wdog_cnt <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q <= req_arr[gnt_idx];
        id_q <= gnt_idx;
        ptr  <= ptr_nxt;
      end
      if (capture) begin
        res_q   <= core_result;
        cflag_q <= core_cflag;
        oflag_q <= core_oflag;
      end
`ifdef SQRT_ARB_WATCHDOG_EN
      if (capture) begin
        err_q <= 1'b0;
      end else if (wd_abort) begin
        res_q   <= '0;
        cflag_q <= 1'b0;
        oflag_q <= 1'b0;
        err_q   <= 1'b1;
      end
      // Cleared in ISSUE so the first WAIT cycle counts from zero.
      if (state == ISSUE)     wdog_cnt <= '0;
      else if (state == WAIT) wdog_cnt <= wdog_cnt + 1'b1;
`endif
    end
  end

  // Outputs are forced low while rst is high so nothing leaks out in the
  // reset cycle itself.
  assign req_ready  = (accept && !rst) ? gnt : '0;
  assign core_start = start_c && !rst;
  assign core_nr    = rst ? '0 : op_q;
  assign rsp_valid  = (state == RESP) && !rst;
  assign rsp_id     = rst ? '0 : id_q;
  assign rsp_result = rst ? '0 : res_q;
  assign rsp_cflag  = cflag_q && !rst;
  assign rsp_oflag  = oflag_q && !rst;
`ifdef SQRT_ARB_WATCHDOG_EN
  assign rsp_err    = err_q && !rst;
  assign core_rst   = wd_abort && !rst;
`else
  assign rsp_err    = 1'b0;
  assign core_rst   = 1'b0;
`endif

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Self-checking bench for sqrt_arbiter: a timestamp-based behavioural model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_sqrt_arbiter;
  localparam int N   = 4;
  localparam int WDL = 40;
`ifdef SQRT_ARB_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [32*N-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [1:0]      rsp_id;
  logic [15:0]     rsp_result;
  logic            rsp_cflag, rsp_oflag, rsp_err;
  logic            core_start;
  logic [31:0]     core_nr;
  logic            core_ready = 1'b0;
  logic [15:0]     core_result = '0;
  logic            core_cflag = 1'b0, core_oflag = 1'b0;
  logic            core_rst;

  sqrt_arbiter #(.N(N), .WDOG_LIMIT(WDL)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_cflag(rsp_cflag),
    .rsp_oflag(rsp_oflag), .rsp_err(rsp_err), .core_start(core_start),
    .core_nr(core_nr), .core_ready(core_ready), .core_result(core_result),
    .core_cflag(core_cflag), .core_oflag(core_oflag), .core_rst(core_rst)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] isqrt(input logic [31:0] x);
    longint r, t;
    r = 0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (longint'(1) << b);
      if (t * t <= longint'({32'd0, x})) r = t;
    end
    return 16'(r);
  endfunction

  function automatic int first_from(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // ---------------- core model (stimulus for the core-side inputs) --------
  int          due = -1;
  logic [15:0] pend_res = '0;
  logic        pend_cf = 1'b0, pend_of = 1'b0;
  logic        never_ready = 1'b0;
  logic        stray = 1'b0;

  always @(negedge clk) begin
    if (rst || core_rst) due = -1;
    else if (core_start && !never_ready) begin
      due      = cyc + (core_nr[31] ? 1 : 33);
      pend_res = core_nr[31] ? 16'd0 : isqrt(core_nr);
      pend_cf  = core_nr[31];
      pend_of  = core_nr[30] && !core_nr[31];
    end
  end

  always @(posedge clk) begin
    #2;
    core_ready  = stray || (due >= 0 && cyc == due);
    core_result = stray ? 16'hDEAD : pend_res;
    core_cflag  = stray ? 1'b0 : pend_cf;
    core_oflag  = stray ? 1'b0 : pend_of;
  end

  // ---------------- behavioural model + per-cycle compare -----------------
  logic        m_busy = 1'b0, m_resp = 1'b0;
  int          m_acc = 0, m_ptr = 0, m_id = 0, mg, mc;
  logic [31:0] m_op = '0;
  logic [15:0] m_res = '0;
  logic        m_cf = 1'b0, m_of = 1'b0, m_err = 1'b0, m_wd;
  logic [N-1:0] m_exp_rr;

  always @(negedge clk) begin
    mc   = cyc;
    mg   = -1;
    m_wd = 1'b0;
    if (rst) begin
      check("rst req_ready",  32'(req_ready), 0);
      check("rst rsp_valid",  32'(rsp_valid), 0);
      check("rst core_start", 32'(core_start), 0);
      check("rst core_nr",    core_nr, 0);
      check("rst core_rst",   32'(core_rst), 0);
      check("rst rsp_result", 32'(rsp_result), 0);
      check("rst rsp_id",     32'(rsp_id), 0);
      check("rst rsp_err",    32'(rsp_err), 0);
    end else begin
      mg = m_busy ? -1 : first_from(req_valid, m_ptr);
      m_exp_rr = '0;
      if (mg >= 0) m_exp_rr[mg] = 1'b1;
      m_wd = WD_EN && m_busy && !m_resp && (mc == m_acc + 2 + WDL) && !core_ready;
      check("model req_ready",  32'(req_ready), 32'(m_exp_rr));
      check("model core_start", 32'(core_start), 32'(m_busy && !m_resp && mc == m_acc + 1));
      check("model core_nr",    core_nr, m_op);
      check("model rsp_valid",  32'(rsp_valid), 32'(m_resp));
      check("model core_rst",   32'(core_rst), 32'(m_wd));
      if (m_resp) begin
        check("model rsp_id",     32'(rsp_id), 32'(m_id));
        check("model rsp_result", 32'(rsp_result), 32'(m_res));
        check("model rsp_cflag",  32'(rsp_cflag), 32'(m_cf));
        check("model rsp_oflag",  32'(rsp_oflag), 32'(m_of));
        check("model rsp_err",    32'(rsp_err), 32'(m_err));
      end
    end
    if (rst) begin
      m_busy = 0; m_resp = 0; m_ptr = 0; m_id = 0; m_op = '0;
      m_res = '0; m_cf = 0; m_of = 0; m_err = 0;
    end else if (!m_busy) begin
      if (mg >= 0) begin
        m_busy = 1; m_acc = mc; m_id = mg;
        m_op   = req_data[mg*32 +: 32];
        m_ptr  = (mg + 1) % N;
      end
    end else if (m_resp) begin
      if (rsp_ready) begin m_busy = 0; m_resp = 0; end
    end else if (mc >= m_acc + 2) begin
      if (core_ready) begin
        m_resp = 1; m_res = core_result; m_cf = core_cflag; m_of = core_oflag; m_err = 0;
      end else if (m_wd) begin
        m_resp = 1; m_res = '0; m_cf = 0; m_of = 0; m_err = 1;
      end
    end
  end

  // ---------------- directed stimulus --------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int limit, output int t);
    t = -1;
    for (int k = 0; k < limit && t < 0; k++) begin
      @(negedge clk);
      if (rsp_valid) t = cyc;
      else tick();
    end
  endtask

  task automatic single(input int id, input logic [31:0] data, input int exp_lat,
                        input logic [15:0] exp_res, input logic exp_cf, input logic exp_of);
    int t0, tr;
    req_data[id*32 +: 32] = data;
    req_valid = '0;
    req_valid[id] = 1'b1;
    @(negedge clk);
    check("single req_ready", 32'(req_ready), 32'(1) << id);
    t0 = cyc;
    tick();
    req_valid = '0;
    @(negedge clk);
    check("single core_start", 32'(core_start), 1);
    tick();
    wait_rsp(60, tr);
    check("single latency", 32'(tr - t0), 32'(exp_lat));
    check("single rsp_id", 32'(rsp_id), 32'(id));
    check("single rsp_result", 32'(rsp_result), 32'(exp_res));
    check("single rsp_cflag", 32'(rsp_cflag), 32'(exp_cf));
    check("single rsp_oflag", 32'(rsp_oflag), 32'(exp_of));
    tick();
  endtask

  int   g_idx [8];
  int   g_cyc [8];
  int   exp_order [5] = '{0, 1, 2, 3, 0};
  int   ng, t0, tr, wd_t;
  logic prev, saw;
  logic [15:0] held;

  initial begin
    // Reset state
    rst = 1'b1; req_valid = '1;
    tick(); tick();
    rst = 1'b0; req_valid = '0;
    @(negedge clk);
    check("reset req_ready", 32'(req_ready), 0);
    check("reset rsp_valid", 32'(rsp_valid), 0);
    check("reset core_nr", core_nr, 0);
    check("reset rsp_err", 32'(rsp_err), 0);
    tick();

    // Single request, early exit, large operand
    single(2, 32'd144, 35, 16'd12, 1'b0, 1'b0);
    single(0, 32'h8000_0000, 3, 16'd0, 1'b1, 1'b0);
    single(1, 32'h4000_0000, 35, 16'd32768, 1'b0, 1'b1);

    // Contention from reset
    rst = 1'b1;
    req_data = {32'd16, 32'd9, 32'd4, 32'd1};
    req_valid = '1;
    tick();
    rst = 1'b0;
    ng = 0; prev = 1'b0;
    for (int k = 0; k < 250 && ng < 5; k++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        check("contention onehot", 32'($onehot(req_ready)), 1);
        check("contention req_ready width", 32'(prev), 0);
        for (int b = 0; b < N; b++) if (req_ready[b]) g_idx[ng] = b;
        g_cyc[ng] = cyc;
        ng++;
      end
      prev = (req_ready != '0);
      tick();
      if (ng == 5) req_valid = '0;
    end
    check("contention grant count", 32'(ng), 5);
    for (int i = 0; i < 5; i++) check("contention order", 32'(g_idx[i]), 32'(exp_order[i]));
    for (int i = 0; i < 4; i++) check("contention spacing", 32'(g_cyc[i+1] - g_cyc[i]), 36);
    wait_rsp(60, tr);
    check("contention last result", 32'(rsp_result), 1);
    tick();

    // Backpressure (ptr is 1 here)
    rsp_ready = 1'b0;
    req_data[1*32 +: 32] = 32'd10000;
    req_data[3*32 +: 32] = 32'd81;
    req_valid = 4'b1010;
    @(negedge clk);
    check("bp grant", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b1000;
    wait_rsp(60, tr);
    held = rsp_result;
    check("bp result", 32'(held), 100);
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) begin
        tick();
        stray = (k == 3);
        @(negedge clk);
      end
      check("bp rsp_valid", 32'(rsp_valid), 1);
      check("bp result stable", 32'(rsp_result), 32'(held));
      check("bp rsp_id", 32'(rsp_id), 1);
      check("bp no req_ready", 32'(req_ready), 0);
    end
    tick();
    stray = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp 6th rsp_valid", 32'(rsp_valid), 1);
    tick();
    @(negedge clk);
    check("bp idle rsp_valid", 32'(rsp_valid), 0);
    check("bp re-accept", 32'(req_ready), 32'b1000);
    tick();
    req_valid = '0;
    wait_rsp(60, tr);
    check("bp second result", 32'(rsp_result), 9);
    tick();

    // Reset mid-WAIT (ptr is 0; granting 2 moves it to 3)
    req_data[2*32 +: 32] = 32'd400;
    req_valid = 4'b0100;
    @(negedge clk);
    check("rstwait grant", 32'(req_ready), 32'b0100);
    t0 = cyc;
    tick();
    req_valid = '0;
    for (int k = 2; k <= 10; k++) tick();
    rst = 1'b1;
    @(negedge clk);
    check("rstwait cycle", 32'(cyc - t0), 10);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rstwait core_nr", core_nr, 0);
    check("rstwait rsp_valid", 32'(rsp_valid), 0);
    check("rstwait rsp_result", 32'(rsp_result), 0);
    check("rstwait core_start", 32'(core_start), 0);
    saw = 1'b0;
    for (int k = 0; k < 45; k++) begin
      tick();
      stray = (k == 5);
      @(negedge clk);
      if (rsp_valid) saw = 1'b1;
    end
    tick();
    stray = 1'b0;
    check("rstwait dropped", 32'(saw), 0);
    req_data[1*32 +: 32] = 32'd49;
    req_data[3*32 +: 32] = 32'd64;
    req_valid = 4'b1010;
    @(negedge clk);
    check("rstwait ptr zero", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    wait_rsp(60, tr);
    check("rstwait next result", 32'(rsp_result), 7);
    tick();

`ifdef SQRT_ARB_WATCHDOG_EN
    // Watchdog: core never answers (ptr is 2, requester 0 wins)
    never_ready = 1'b1;
    req_data[0 +: 32] = 32'd25;
    req_valid = 4'b0001;
    @(negedge clk);
    check("wd grant", 32'(req_ready), 32'b0001);
    t0 = cyc;
    tick();
    req_valid = '0;
    wd_t = -1;
    tr = -1;
    for (int k = 0; k < 80 && tr < 0; k++) begin
      @(negedge clk);
      if (core_rst && wd_t < 0) wd_t = cyc;
      if (rsp_valid) tr = cyc;
      else tick();
    end
    check("wd core_rst cycle", 32'(wd_t - t0), 42);
    check("wd rsp cycle", 32'(tr - t0), 43);
    check("wd rsp_err", 32'(rsp_err), 1);
    check("wd rsp_result", 32'(rsp_result), 0);
    tick();
    never_ready = 1'b0;
`endif

    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global timeout: cycle %0d, expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
